// File: rtl/gsm_burst_feeder_pkg.sv
// gsm_burst_feeder_pkg: burst field lengths, FSM states and the GSM training sequence table
package gsm_burst_feeder_pkg;

    localparam int TAIL_LEN  = 3;
    localparam int DATA_LEN  = 58;
    localparam int TRAIN_LEN = 26;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAIL_H,
        S_DATA_A,
        S_TRAIN,
        S_DATA_B,
        S_TAIL_T,
        S_GUARD
    } state_t;

    // GSM normal-burst training sequences, transmitted MSB first
    function automatic logic [25:0] tsc_lookup(input logic [2:0] sel);
        case (sel)
            3'd0:    return 26'h0970897;
            3'd1:    return 26'h0B778B7;
            3'd2:    return 26'h10EE90E;
            3'd3:    return 26'h11ED11E;
            3'd4:    return 26'h06B906B;
            3'd5:    return 26'h13AC13A;
            3'd6:    return 26'h29F629F;
            default: return 26'h3BC4BBC;
        endcase
    endfunction

    function automatic logic [7:0] field_len(input state_t s, input logic [7:0] guard_len);
        return (s == S_TAIL_H || s == S_TAIL_T) ? 8'(TAIL_LEN) :
               (s == S_DATA_A || s == S_DATA_B) ? 8'(DATA_LEN) :
               (s == S_TRAIN)                   ? 8'(TRAIN_LEN) :
               (s == S_GUARD)                   ? guard_len : 8'd1;
    endfunction

    function automatic state_t next_field(input state_t s);
        return (s == S_TAIL_H) ? S_DATA_A :
               (s == S_DATA_A) ? S_TRAIN  :
               (s == S_TRAIN)  ? S_DATA_B :
               (s == S_DATA_B) ? S_TAIL_T :
               (s == S_TAIL_T) ? S_GUARD  : S_IDLE;
    endfunction

endpackage

// File: rtl/gsm_burst_feeder_if.sv
// gsm_burst_feeder_if: burst request, payload bit stream and modulator drive signals
interface gsm_burst_feeder_if;
    logic       start_burst;
    logic [2:0] tsc_select;
    logic       bit_valid;
    logic       bit_data;
    logic       bit_ready;
    logic       symbol_strobe;
    logic       sample_strobe;
    logic       input_bit;
    logic       busy;
    logic       burst_done;
    logic       underrun;

    // master: the controller requesting bursts and supplying payload bits
    modport master (
        output start_burst, tsc_select, bit_valid, bit_data,
        input  bit_ready, symbol_strobe, sample_strobe, input_bit, busy, burst_done, underrun
    );

    // slave: the burst feeder itself
    modport slave (
        input  start_burst, tsc_select, bit_valid, bit_data,
        output bit_ready, symbol_strobe, sample_strobe, input_bit, busy, burst_done, underrun
    );
endinterface

// File: rtl/gsm_burst_feeder_strobe.sv
// gsm_burst_feeder_strobe: free-running sample/symbol strobe divider with a one-cycle symbol look-ahead
module gsm_burst_feeder_strobe #(
    parameter int CLOCKS_PER_SAMPLE  = 4,
    parameter int SAMPLES_PER_SYMBOL = 128
) (
    input  logic clk,
    input  logic rst,
    output logic sample_strobe_o,
    output logic symbol_strobe_o,
    output logic pre_symbol_o
);
    localparam int CW = CLOCKS_PER_SAMPLE > 1 ? $clog2(CLOCKS_PER_SAMPLE) : 1;
    localparam int SW = SAMPLES_PER_SYMBOL > 1 ? $clog2(SAMPLES_PER_SYMBOL) : 1;

    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [SW-1:0] smp_cnt_q, smp_cnt_d;
    logic          sample_q, symbol_q;
    logic          wrap;

    assign wrap            = clk_cnt_q == CW'(CLOCKS_PER_SAMPLE - 1);
    assign pre_symbol_o    = wrap && smp_cnt_q == '0;
    assign sample_strobe_o = sample_q;
    assign symbol_strobe_o = symbol_q;

    // divider counters: clock count wraps every sample, sample count wraps every symbol
    always_comb begin
        clk_cnt_d = wrap ? '0 : clk_cnt_q + CW'(1);
        smp_cnt_d = !wrap ? smp_cnt_q :
                    smp_cnt_q == SW'(SAMPLES_PER_SYMBOL - 1) ? '0 : smp_cnt_q + SW'(1);
    end

    // registered strobes; a symbol strobe is the sample strobe that starts sample 0
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt_q <= '0;
            smp_cnt_q <= '0;
            sample_q  <= 1'b0;
            symbol_q  <= 1'b0;
        end else begin
            clk_cnt_q <= clk_cnt_d;
            smp_cnt_q <= smp_cnt_d;
            sample_q  <= wrap;
            symbol_q  <= pre_symbol_o;
        end
    end
endmodule

// File: rtl/gsm_burst_feeder.sv
// gsm_burst_feeder: assembles, differentially encodes and paces one GSM normal burst per request
module gsm_burst_feeder
    import gsm_burst_feeder_pkg::*;
#(
    parameter int CLOCKS_PER_SAMPLE  = 4,
    parameter int SAMPLES_PER_SYMBOL = 128,
    parameter int GUARD_SYMBOLS      = 8
) (
    input  logic              clk,
    input  logic              rst,
    gsm_burst_feeder_if.slave bus
);
    localparam logic [7:0] GUARD_LEN = 8'(GUARD_SYMBOLS);

    state_t      state_q, state_d, cur;
    logic [7:0]  fcnt_q, fcnt_d;
    logic [25:0] tsc_q, tsc_d, tsc_cur;
    logic        prev_q, prev_d;
    logic        bit_q, bit_d;
    logic        done_q, done_d;
    logic        under_q, under_d;
    logic        pre_symbol, accept, last, is_data, d, p;

    gsm_burst_feeder_strobe #(
        .CLOCKS_PER_SAMPLE (CLOCKS_PER_SAMPLE),
        .SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)
    ) u_strobe (
        .clk            (clk),
        .rst            (rst),
        .sample_strobe_o(bus.sample_strobe),
        .symbol_strobe_o(bus.symbol_strobe),
        .pre_symbol_o   (pre_symbol)
    );

    // an accepted start acts as TAIL_H immediately so a start on the load cycle is not delayed a symbol
    always_comb begin
        accept  = state_q == S_IDLE && !done_q && bus.start_burst;
        cur     = accept ? S_TAIL_H : state_q;
        tsc_cur = accept ? tsc_lookup(bus.tsc_select) : tsc_q;
        last    = fcnt_q == field_len(cur, GUARD_LEN) - 8'd1;
        is_data = cur == S_DATA_A || cur == S_DATA_B;
        d       = (cur == S_TAIL_H || cur == S_TAIL_T) ? 1'b0 :
                  (cur == S_GUARD) ? 1'b1 :
                  (cur == S_TRAIN) ? tsc_cur[25] : bus.bit_valid & bus.bit_data;
        p       = (cur == S_TAIL_H && fcnt_q == '0) ? 1'b1 : prev_q;
        state_d = cur;
        fcnt_d  = fcnt_q;
        tsc_d   = tsc_cur;
        prev_d  = prev_q;
        bit_d   = bit_q;
        done_d  = 1'b0;
        under_d = accept ? 1'b0 : under_q;
        if (pre_symbol) begin
            bit_d = 1'b0;
            if (cur != S_IDLE) begin
                bit_d   = d ^ p;
                prev_d  = d;
                tsc_d   = cur == S_TRAIN ? {tsc_cur[24:0], 1'b0} : tsc_cur;
                under_d = under_d | (is_data & ~bus.bit_valid);
                fcnt_d  = last ? '0 : fcnt_q + 8'd1;
                state_d = last ? next_field(cur) : cur;
                done_d  = last && cur == S_GUARD;
            end
        end
    end

    // burst state, encoder history and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            fcnt_q  <= '0;
            tsc_q   <= '0;
            prev_q  <= 1'b1;
            bit_q   <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            tsc_q   <= tsc_d;
            prev_q  <= prev_d;
            bit_q   <= bit_d;
            done_q  <= done_d;
            under_q <= under_d;
        end
    end

    assign bus.bit_ready  = pre_symbol && is_data;
    assign bus.input_bit  = bit_q;
    assign bus.busy       = state_q != S_IDLE;
    assign bus.burst_done = done_q;
    assign bus.underrun   = under_q;
endmodule

// File: tb/tb_gsm_burst_feeder.sv
// tb_gsm_burst_feeder: random-payload bursts checked cycle by cycle against a flat burst-index model
module tb_gsm_burst_feeder;
    localparam int CPS  = 3;
    localparam int SPS  = 4;
    localparam int G    = 8;
    localparam int SYM  = CPS * SPS;
    localparam int NSYM = 148 + G;

    logic clk = 1'b0;
    logic rst = 1'b1;
    gsm_burst_feeder_if bus();

    gsm_burst_feeder #(
        .CLOCKS_PER_SAMPLE (CPS),
        .SAMPLES_PER_SYMBOL(SPS),
        .GUARD_SYMBOLS     (G)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [25:0] tsc_tab [8] = '{26'h0970897, 26'h0B778B7, 26'h10EE90E, 26'h11ED11E,
                                 26'h06B906B, 26'h13AC13A, 26'h29F629F, 26'h3BC4BBC};

    int          t = 0;
    bit          armed = 0;
    bit          m_busy = 0;
    bit          m_prev = 1;
    bit          m_under = 0;
    int          m_idx = 0;
    logic [25:0] m_tsc = '0;
    logic [5:0]  e = '0;
    int          ncap = 0;
    int          nxfer = 0;
    int          ndone = 0;
    logic        cap [256];
    int          vmode = 0;
    int          hole = -1;

    function automatic bit is_data(input int i);
        return (i >= 3 && i < 61) || (i >= 87 && i < 145);
    endfunction

    function automatic bit sym_d(input int i, input logic [25:0] tsc, input bit pay);
        if (i < 3) return 1'b0;
        if (i < 61) return pay;
        if (i < 87) return tsc[25 - (i - 61)];
        if (i < 145) return pay;
        if (i < 148) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [6:0] outs();
        return {bus.sample_strobe, bus.symbol_strobe, bus.input_bit, bus.busy,
                bus.burst_done, bus.underrun, bus.bit_ready};
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // one clock: compare at the negedge, advance the model, then drive fresh payload inputs
    task automatic step();
        bit pre, samp, acc, beff, rdy, v, dd, p, nbit, ndn;
        int idx_eff;
        logic [6:0] got, exp;
        @(negedge clk);
        pre     = (t + 1 >= CPS) && ((t + 1 - CPS) % SYM == 0);
        samp    = ((t + 1) % CPS) == 0;
        acc     = !m_busy && !e[1] && bus.start_burst;
        beff    = m_busy || acc;
        idx_eff = acc ? 0 : m_idx;
        rdy     = pre && beff && is_data(idx_eff);
        got     = outs();
        exp     = {e, rdy};
        if (armed) begin
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL cycle t=%0d {smp,sym,bit,busy,done,und,rdy} got %b expected %b", t, got, exp);
            end
        end
        if (acc) begin
            ncap  = 0;
            nxfer = 0;
        end
        if (bus.burst_done) ndone++;
        if (bus.symbol_strobe && (bus.busy || bus.burst_done) && ncap < 256) begin
            cap[ncap] = bus.input_bit;
            ncap++;
        end
        if (bus.bit_ready && bus.bit_valid) nxfer++;
        if (rst) begin
            e       = '0;
            m_busy  = 0;
            m_prev  = 1;
            m_under = 0;
            m_idx   = 0;
            t       = 0;
            armed   = 1;
        end else begin
            nbit = e[3];
            ndn  = 0;
            if (acc) begin
                m_busy  = 1;
                m_idx   = 0;
                m_tsc   = tsc_tab[bus.tsc_select];
                m_under = 0;
            end
            if (pre && beff) begin
                v      = bus.bit_valid;
                dd     = sym_d(m_idx, m_tsc, v & bus.bit_data);
                p      = (m_idx == 0) ? 1'b1 : m_prev;
                nbit   = dd ^ p;
                m_prev = dd;
                if (is_data(m_idx) && !v) m_under = 1;
                m_idx++;
                if (m_idx == NSYM) begin
                    m_busy = 0;
                    ndn    = 1;
                end
            end else if (pre) begin
                nbit = 0;
            end
            e = {samp, pre, nbit, m_busy, ndn, m_under};
            t++;
        end
        @(posedge clk);
        #1;
        bus.start_burst = 1'b0;
        bus.bit_valid   = (m_busy && m_idx == hole) ? 1'b0 :
                          vmode == 1 ? ($urandom_range(0, 7) != 0) : 1'b1;
        bus.bit_data    = vmode == 0 ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idx(input int v);
        int n = 0;
        while (m_idx != v && n < NSYM * SYM) begin
            step();
            n++;
        end
        chk("reach_symbol_index", m_idx, v);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!bus.burst_done && n < NSYM * SYM + 4 * SYM) begin
            step();
            n++;
        end
        chk(nm, int'(bus.burst_done), 1);
    endtask

    initial begin
        int n, d0;
        logic [25:0] tr;
        logic [4:0] first5;
        bus.start_burst = 1'b0;
        bus.tsc_select  = 3'd0;
        bus.bit_valid   = 1'b0;
        bus.bit_data    = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_outputs", int'(outs()), 0);
        n = 0;
        while (!bus.sample_strobe && n < 4 * CPS) begin
            step();
            n++;
        end
        chk("first_sample_cycle", n, CPS);
        chk("first_sample_is_symbol", int'(bus.symbol_strobe), 1);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.symbol_strobe && n < 2 * SYM);
        chk("symbol_period", n, SYM);

        vmode = 0;
        hole  = -1;
        step();
        bus.start_burst = 1'b1;
        bus.tsc_select  = 3'd0;
        d0 = ndone;
        step();
        chk("busy_after_start", int'(bus.busy), 1);
        wait_idx(40);
        bus.start_burst = 1'b1;
        bus.tsc_select  = 3'd5;
        step();
        chk("busy_ignores_start", int'(bus.busy), 1);
        wait_done("burst_a_done");
        bus.start_burst = 1'b1;
        bus.tsc_select  = 3'd2;
        step();
        chk("start_on_done_ignored", int'(bus.busy), 0);
        chk("burst_a_symbols", ncap, 156);
        chk("burst_a_transfers", nxfer, 116);
        chk("burst_a_done_count", ndone - d0, 1);
        first5 = {cap[0], cap[1], cap[2], cap[3], cap[4]};
        chk("burst_a_first5", int'(first5), int'(5'b10010));
        for (int i = 0; i < 26; i++) tr[25 - i] = cap[61 + i];
        chk("burst_a_train_tsc0", int'(tr), int'(26'h2DC8CDC));

        vmode = 2;
        hole  = 97;
        bus.start_burst = 1'b1;
        bus.tsc_select  = 3'($urandom_range(0, 7));
        d0 = ndone;
        step();
        chk("start_after_done", int'(bus.busy), 1);
        wait_idx(97);
        chk("underrun_before_hole", int'(bus.underrun), 0);
        wait_idx(98);
        chk("underrun_at_hole", int'(bus.underrun), 1);
        wait_done("burst_b_done");
        step();
        chk("burst_b_transfers", nxfer, 115);
        chk("burst_b_done_count", ndone - d0, 1);
        chk("underrun_sticky", int'(bus.underrun), 1);

        vmode = 1;
        hole  = -1;
        bus.start_burst = 1'b1;
        bus.tsc_select  = 3'($urandom_range(0, 7));
        step();
        chk("underrun_cleared", int'(bus.underrun), 0);
        wait_idx(24);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("reset_mid_burst_outputs", int'(outs()), 0);
        d0 = ndone;
        repeat (3 * SYM) step();
        chk("no_done_after_reset", ndone - d0, 0);

        bus.start_burst = 1'b1;
        bus.tsc_select  = 3'($urandom_range(0, 7));
        step();
        n = 0;
        while (ncap == 0 && n < 4 * SYM) begin
            step();
            n++;
        end
        chk("post_reset_first_dhat", int'(cap[0]), 1);
        wait_done("burst_d_done");

        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(1, 2 * SYM)) step();
            bus.start_burst = 1'b1;
            bus.tsc_select  = 3'($urandom_range(0, 7));
            step();
            chk("random_burst_busy", int'(bus.busy), 1);
            wait_done("random_burst_done");
        end
        repeat (SYM) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
